spi_slave_if: RTL and testbench

- SPI slave front-end that feeds the dual-port RAM command port.
- Deserialises MOSI frames into 10-bit commands and presents them as rx_data with a one-cycle rx_valid strobe.
- For read-data commands, waits for the RAM's tx_valid/tx_data response and serialises the byte onto MISO.
- Sits between the SPI pins and the RAM inside the SPI wrapper; one system clock, no SCK domain (MOSI is sampled every clk while SS_n is low).

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_piso.sv | 40 ++++
 rtl/spi_slave_if.sv | 169 ++++++++++++++++
 tb/tb_spi_slave_if.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front-end.
// - spi_state_e : receive/transmit FSM states
// - OP_*        : command opcodes carried in rx_data[FRAME_W-1:FRAME_W-2]
// - FRAME_W     : command frame width for the default payload width
package spi_pkg;

   localparam int unsigned DATA_W_DFLT = 8;
   localparam int unsigned FRAME_W     = DATA_W_DFLT + 2;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StChkCmd,
      StWrite,
      StReadAdd,
      StReadData
   } spi_state_e;

endpackage

// File: rtl/spi_piso.sv
// Parallel-load, serial-out shifter for the MISO path (MSB first).
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   load       : capture din (has priority over shift_en)
//   shift_en   : move the next lower bit into the MSB position
//   din        : parallel data to send
//   dout       : current serial bit (MSB of the shifter)
module spi_piso #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              shift_en,
   input  logic [DATA_W-1:0] din,
   output logic              dout
);

   logic [DATA_W-1:0] shreg_q, shreg_d;

   always_comb begin
      shreg_d = shreg_q;
      if (load) begin
         shreg_d = din;
      end else if (shift_en) begin
         shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q <= '0;
      end else begin
         shreg_q <= shreg_d;
      end
   end

   assign dout = shreg_q[DATA_W-1];

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front-end for the dual-port RAM command port.
// MOSI is sampled on every clk while SS_n is low; a complete DATA_W+2 bit frame is
// presented on rx_data with a one-cycle rx_valid strobe. For read-data commands the
// RAM's tx_data byte is serialised onto MISO, MSB first.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   SS_n, MOSI : slave select (active low) and serial input
//   MISO       : serial output, 0 when not shifting
//   rx_data    : last complete command frame, rx_valid strobes once per frame
//   tx_data    : read byte from the RAM, qualified by tx_valid
module spi_slave_if
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DFLT,
   // Must satisfy 2**CNT_W > DATA_W + 2 so the counter can reach "frame done".
   parameter int unsigned CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic [DATA_W+1:0] rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid
);

   localparam int unsigned       FrameW    = DATA_W + 2;
   localparam logic [CNT_W-1:0] LastBit   = CNT_W'(FrameW - 1);
   localparam logic [CNT_W-1:0] FrameDone = CNT_W'(FrameW);
   localparam logic [CNT_W-1:0] TxLast    = CNT_W'(DATA_W - 1);

   spi_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   // Holds every frame bit except the one arriving on the completing edge.
   logic [FrameW-2:0] sipo_q, sipo_d;
   logic [FrameW-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              rd_seen_q, rd_seen_d;
   logic              tx_busy_q, tx_busy_d;
   logic              tx_done_q, tx_done_d;
   logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
   logic              piso_load, piso_shift, piso_bit;
   logic              frame_done;

   assign frame_done = (cnt_q == FrameDone);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sipo_d     = sipo_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rd_seen_d  = rd_seen_q;
      tx_busy_d  = tx_busy_q;
      tx_done_d  = tx_done_q;
      tx_cnt_d   = tx_cnt_q;
      piso_load  = 1'b0;
      piso_shift = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!SS_n) begin
               state_d   = StChkCmd;
               cnt_d     = '0;
               tx_busy_d = 1'b0;
               tx_done_d = 1'b0;
            end
         end
         StChkCmd: begin
            sipo_d = {sipo_q[FrameW-3:0], MOSI};
            cnt_d  = cnt_q + 1'b1;
            // Opcode MSB picks write vs read; a read is the data phase only once
            // a read-address frame has been seen.
            if (MOSI == OP_WR_ADDR[1]) begin
               state_d = StWrite;
            end else if (rd_seen_q) begin
               state_d = StReadData;
            end else begin
               state_d = StReadAdd;
            end
         end
         StWrite, StReadAdd, StReadData: begin
            if (!frame_done) begin
               sipo_d = {sipo_q[FrameW-3:0], MOSI};
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == LastBit) begin
                  rx_data_d  = {sipo_q, MOSI};
                  rx_valid_d = 1'b1;
                  if (state_q == StReadAdd) begin
                     rd_seen_d = 1'b1;
                  end else if (state_q == StReadData) begin
                     rd_seen_d = 1'b0;
                  end
               end
            end else if (state_q == StReadData) begin
               if (tx_busy_q) begin
                  if (tx_cnt_q == TxLast) begin
                     tx_busy_d = 1'b0;
                     tx_done_d = 1'b1;
                  end else begin
                     piso_shift = 1'b1;
                     tx_cnt_d   = tx_cnt_q + 1'b1;
                  end
               end else if (!tx_done_q && tx_valid) begin
                  // Only the first response after the frame is accepted.
                  piso_load = 1'b1;
                  tx_busy_d = 1'b1;
                  tx_cnt_d  = '0;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Deselect aborts everything in flight; a partial frame leaves no trace.
      if (SS_n && (state_q != StIdle)) begin
         state_d    = StIdle;
         rx_data_d  = rx_data_q;
         rx_valid_d = 1'b0;
         rd_seen_d  = rd_seen_q;
         tx_busy_d  = 1'b0;
         tx_done_d  = 1'b0;
         piso_load  = 1'b0;
         piso_shift = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         sipo_q     <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rd_seen_q  <= 1'b0;
         tx_busy_q  <= 1'b0;
         tx_done_q  <= 1'b0;
         tx_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sipo_q     <= sipo_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rd_seen_q  <= rd_seen_d;
         tx_busy_q  <= tx_busy_d;
         tx_done_q  <= tx_done_d;
         tx_cnt_q   <= tx_cnt_d;
      end
   end

   spi_piso #(
      .DATA_W(DATA_W)
   ) u_piso (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (piso_load),
      .shift_en (piso_shift),
      .din      (tx_data),
      .dout     (piso_bit)
   );

   assign MISO     = tx_busy_q & piso_bit;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: transaction-level model of frames, read
// responses and aborts, compared against the DUT on every falling clock edge.
module tb_spi_slave_if;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       SS_n = 1'b1;
   logic       MOSI = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = '0;
   logic       MISO;
   logic       rx_valid;
   logic [9:0] rx_data;

   int total = 0;
   int bad   = 0;

   // Model state and expected outputs.
   bit         chk_en = 1'b0;
   bit         seen = 1'b0;
   logic [9:0] model_rx = '0;
   logic       exp_miso = 1'b0;
   logic       exp_rx_valid = 1'b0;
   logic [9:0] exp_rx_data = '0;
   int         pulses;
   logic [7:0] cap;

   always #5 clk = ~clk;

   spi_slave_if dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("rx_valid", 32'(rx_valid), 32'(exp_rx_valid));
         check("rx_data", 32'(rx_data), 32'(exp_rx_data));
         check("miso", 32'(MISO), 32'(exp_miso));
      end
   end

   // One SS_n-low transaction. Edge t=0 is the first edge seeing SS_n low.
   // nbits >= 10: full frame; otherwise SS_n is seen high at edge nbits+1.
   // dly >= 0: RAM answers a read-data frame with tx_valid sampled at edge 12+dly.
   // rst_at >= 0: reset is pulsed just after that edge.
   task automatic run_txn(input logic [9:0] frame, input int nbits, input int dly,
                          input logic [7:0] resp, input bit spur, input int rst_at);
      bit full    = (nbits >= 10);
      bit rdd     = full && frame[9] && seen;
      bit resp_on = rdd && (dly >= 0);
      int win     = 12 + dly;
      int tail    = int'($urandom_range(0, 3));
      int end_e;
      end_e  = !full ? nbits + 1 : (resp_on ? win + 9 + tail : 11 + tail);
      pulses = 0;
      cap    = '0;
      for (int t = 0; t <= end_e; t++) begin
         SS_n     = (t == end_e);
         MOSI     = (t >= 1 && t <= 10) ? frame[10-t] : 1'($urandom);
         tx_data  = 8'($urandom);
         tx_valid = 1'b0;
         if (resp_on && t == win) begin
            tx_valid = 1'b1;
            tx_data  = resp;
         end else if (spur && (!rdd || t <= 10 || (resp_on && t > win)) &&
                      ($urandom_range(0, 2) == 0)) begin
            tx_valid = 1'b1;
         end
         @(posedge clk);
         #1;
         if (full && t == 10) begin
            model_rx = frame;
            if (frame[9]) seen = !seen;
         end
         exp_rx_valid = full && (t == 10);
         exp_rx_data  = model_rx;
         exp_miso     = (resp_on && t >= win && t <= win + 7) ? resp[7-(t-win)] : 1'b0;
         if (rx_valid === 1'b1) pulses++;
         if (resp_on && t >= win && t <= win + 7) cap[7-(t-win)] = MISO;
         if (t == rst_at) begin
            rst_n        = 1'b0;
            model_rx     = '0;
            seen         = 1'b0;
            exp_rx_valid = 1'b0;
            exp_rx_data  = '0;
            exp_miso     = 1'b0;
            #1;
            check("rst_miso", 32'(MISO), 32'h0);
            check("rst_rx_valid", 32'(rx_valid), 32'h0);
            check("rst_rx_data", 32'(rx_data), 32'h0);
            SS_n     = 1'b1;
            tx_valid = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            break;
         end
      end
      tx_valid = 1'b0;
      SS_n     = 1'b1;
   endtask

   task automatic idle(input int n, input bit spur);
      for (int i = 0; i < n; i++) begin
         SS_n     = 1'b1;
         MOSI     = 1'($urandom);
         tx_data  = 8'($urandom);
         tx_valid = spur ? 1'($urandom) : 1'b0;
         @(posedge clk);
         #1;
         exp_rx_valid = 1'b0;
         exp_miso     = 1'b0;
      end
      tx_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset_miso", 32'(MISO), 32'h0);
      check("reset_rx_valid", 32'(rx_valid), 32'h0);
      check("reset_rx_data", 32'(rx_data), 32'h0);
      chk_en = 1'b1;
      rst_n  = 1'b1;
      idle(2, 1'b0);

      // Write address 0x3C.
      run_txn(10'h03C, 10, -1, 8'h00, 1'b0, -1);
      check("wa_rx_data", 32'(rx_data), 32'h03C);
      check("wa_pulses", 32'(pulses), 32'd1);
      idle(2, 1'b1);

      // Write data 0xA5 with spurious tx_valid.
      run_txn(10'h1A5, 10, -1, 8'h00, 1'b1, -1);
      check("wd_rx_data", 32'(rx_data), 32'h1A5);
      check("wd_pulses", 32'(pulses), 32'd1);
      idle(2, 1'b1);

      // Read address then read data answered with 0xA5.
      run_txn(10'h23C, 10, -1, 8'h00, 1'b0, -1);
      idle(1, 1'b0);
      run_txn(10'h300, 10, 0, 8'hA5, 1'b0, -1);
      check("rd_byte", 32'(cap), 32'h0A5);
      check("rd_rx_data", 32'(rx_data), 32'h300);
      idle(1, 1'b0);

      // Abort after 5 data bits, then a clean frame.
      run_txn(10'h155, 5, -1, 8'h00, 1'b0, -1);
      check("ab_pulses", 32'(pulses), 32'd0);
      check("ab_rx_data", 32'(rx_data), 32'h300);
      idle(1, 1'b0);
      run_txn(10'h0F0, 10, -1, 8'h00, 1'b0, -1);
      check("post_ab_rx_data", 32'(rx_data), 32'h0F0);
      idle(2, 1'b0);

      // Reset while MISO is shifting, then a full read sequence.
      run_txn(10'h2AA, 10, -1, 8'h00, 1'b0, -1);
      idle(1, 1'b0);
      run_txn(10'h3AA, 10, 1, 8'h96, 1'b0, 15);
      idle(2, 1'b1);
      run_txn(10'h211, 10, -1, 8'h00, 1'b0, -1);
      idle(1, 1'b0);
      run_txn(10'h300, 10, 0, 8'h5A, 1'b1, -1);
      check("post_rst_byte", 32'(cap), 32'h05A);
      idle(2, 1'b0);

      // Opcode 10 landing in the read-data slot gets no response; MISO stays 0.
      run_txn(10'h2C3, 10, -1, 8'h00, 1'b0, -1);
      idle(1, 1'b0);
      run_txn(10'h281, 10, -1, 8'h00, 1'b1, -1);
      check("rd10_rx_data", 32'(rx_data), 32'h281);
      idle(1, 1'b0);
      run_txn(10'h2FF, 10, -1, 8'h00, 1'b0, -1);
      idle(1, 1'b0);
      run_txn(10'h3FF, 10, 2, 8'hC3, 1'b1, -1);
      check("late_rsp_byte", 32'(cap), 32'h0C3);
      idle(2, 1'b0);

      // Randomised traffic.
      for (int n = 0; n < 40; n++) begin
         run_txn(10'($urandom),
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : 10,
                 int'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), -1);
         idle(int'($urandom_range(1, 3)), 1'($urandom));
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
